// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The host side drives the stream; the loader side drives the write port.
interface imem_loader_if #(
  parameter int N  = 32,
  parameter int AW = 5
);
  logic          byte_valid;
  logic [7:0]    byte_in;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;

  modport master (
    output byte_valid, byte_in,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_in,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles big-endian words from a byte
// stream, writes them from address 0 upward, then verifies an XOR checksum.
module imem_loader #(
  parameter int N     = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   load_len,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t       state, state_n;
  logic [AW:0]  ptr;
  logic [AW:0]  len_q;
  logic [1:0]   bcnt;
  logic [N-1:0] csum;
  logic [N-1:0] shreg;
  logic         accept;
  logic         len_ok;

  assign accept = bus.byte_valid && (state == RECV);
  assign len_ok = (load_len <= DEPTH_L);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_n = len_ok ? RECV : ERR;
      end
      RECV: begin
        // The word completing past the program length is the checksum.
        if (accept && (bcnt == 2'd3)) state_n = (ptr < len_q) ? WRITE : CHECK;
      end
      WRITE:   state_n = RECV;
      CHECK:   state_n = (shreg == csum) ? DONE : ERR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      len_q <= '0;
      bcnt  <= '0;
      csum  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start && len_ok) begin
            ptr   <= '0;
            len_q <= load_len;
            bcnt  <= '0;
            csum  <= '0;
          end
        end
        RECV: begin
          if (accept) begin
            shreg <= {shreg[N-9:0], bus.byte_in};
            bcnt  <= bcnt + 2'd1;
          end
        end
        WRITE: begin
          csum <= csum ^ shreg;
          ptr  <= ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Every output is a decode of registered state; nothing depends on byte_valid.
  always_comb begin
    bus.byte_ready = (state == RECV);
    bus.wr_en      = (state == WRITE);
    bus.wr_addr    = ptr[AW-1:0];
    bus.wr_data    = shreg;
    cpu_hold       = (state != DONE);
    busy           = (state == RECV) || (state == WRITE) || (state == CHECK);
    done           = (state == DONE);
    err            = (state == ERR);
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: it receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes each word to consecutive instruction-memory addresses starting at 0, then verifies an XOR checksum word. It holds the pipelined processor in stall (`cpu_hold`) from reset until a load completes with a matching checksum. It sits between the host/serial front end and the write port of the instruction memory.

## Interface
- `N`, 32, instruction word width (fixed at 32; bytes per word = 4)
- `DEPTH`, 32, instruction memory depth in words
- `AW`, 5, address width, clog2(DEPTH)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a load; sampled only in IDLE, DONE, ERR
- `load_len`  in  AW+1  number of program words, excluding the checksum word; sampled with `start`
- `byte_valid`  in  1  `byte_in` holds a valid byte
- `byte_in`  in  8  stream byte; MSB-first within each word
- `byte_ready`  out  1  loader accepts a byte this cycle
- `wr_en`  out  1  instruction-memory write strobe, 1-cycle pulse
- `wr_addr`  out  AW  word address for write
- `wr_data`  out  N  word to write
- `cpu_hold`  out  1  processor stall request
- `busy`  out  1  load in progress (RECV/WRITE/CHECK)
- `done`  out  1  last load succeeded (level)
- `err`  out  1  last load failed (level)

## Operation
- States: IDLE, RECV, WRITE, CHECK, DONE, ERR.
- A byte is accepted on a cycle where `byte_valid && byte_ready`. `byte_ready` = 1 only in RECV. Bytes offered in any other state are not consumed; the source holds them.
- IDLE/DONE/ERR + `start`:
  - If `load_len` > DEPTH → ERR.
  - Otherwise → RECV. Clear word pointer `ptr`=0, byte count=0, `csum`=0, `done`=0, `err`=0, and set `cpu_hold`=1.
- RECV: on each accepted byte, `shreg <= {shreg[23:0], byte_in}` and the byte count increments modulo 4. On the 4th byte:
  - If `ptr` < `load_len` → WRITE.
  - Otherwise (the word is the checksum) → CHECK.
- WRITE: exactly one cycle. `wr_en`=1, `wr_addr`=`ptr[AW-1:0]`, `wr_data`=`shreg`. Update `csum ^= shreg` and `ptr++`, then → RECV.
- CHECK: exactly one cycle.
  - `shreg == csum` → DONE.
  - Otherwise → ERR.
- DONE: `done`=1, `cpu_hold`=0. ERR: `err`=1, `cpu_hold`=1. Both states are held until `start` or `reset`.
- `load_len`=0: the first word received is the checksum, compared against 0. No writes occur.
- A failed checksum does not undo the writes already made. Memory contents are not owned by the loader and are never cleared by it.
- `wr_addr` never wraps: `ptr` ≤ `load_len` ≤ DEPTH, so the last write goes to DEPTH-1.

## Timing
- Reset values: state IDLE, `byte_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=1, `busy`=0, `done`=0, `err`=0. Internal `ptr`, `csum`, `shreg` and byte count are all 0.
- All outputs are registered or decoded from registered state; there is no combinational path from `byte_valid` to any output.
- Write latency: `wr_en` is high in the cycle immediately after the edge that accepts a word's 4th byte. `byte_ready` is low during that cycle.
- Throughput: best case 5 cycles per program word (4 bytes + 1 WRITE).
- Completion: the 4th checksum byte is accepted at edge k, CHECK occupies cycle k..k+1, and `done`/`err` rise at edge k+1. `cpu_hold` falls at the same edge on success.
- `start` while `busy` is ignored.
- `reset` mid-load takes effect at the next edge. All outputs return to reset values, the partial word is discarded, and `wr_en` is never asserted on or after the reset edge.
- `reset` and `start` in the same cycle: `reset` wins.

## Test plan
- Two-word load: `load_len`=2, bytes 01 29 60 20 01 8F 68 22 00 A6 08 02 with continuous valid → writes addr0=0x01296020, then addr1=0x018F6822; `done`=1, `err`=0, `cpu_hold` 1→0; exactly 2 `wr_en` pulses.
- Bad checksum: same stream but the final byte is 03 → both writes still occur; `err`=1, `done`=0, `cpu_hold` stays 1. A subsequent correct load from ERR → `done`=1.
- Backpressure: `byte_valid` held high, next byte presented only after an accept, with random 0–3-cycle valid gaps → identical writes and data to the two-word case; no byte is consumed during WRITE or CHECK.
- Boundaries: `load_len`=0 with checksum 00 00 00 00 → `done`=1, no `wr_en`. `load_len`=33 → `err`=1 one cycle after `start`, `byte_ready` never asserted. `load_len`=32 → last `wr_addr`=31, `done`=1.
- Reset mid-load: assert `reset` after 6 accepted bytes → next cycle shows all reset values with a single write to addr0 done. A fresh 2-word load then rewrites addr0 and addr1 and completes with `done`=1.
